uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_tx_fifo.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding, data width and
// baud divisor helper. Used by the TX path now and the RX path later.
package uart_pkg;

    localparam int unsigned UART_DATA_WL = 8;

    // PARITY stays in the encoding even when parity generation is disabled.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Integer clock cycles per serial bit.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter so full and empty are
// never ambiguous. Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Occupancy next-state: simultaneous push and pop leave it unchanged.
    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LW'(1);
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: byte FIFO fed by CPU writes, drained by an 8N1 (or 8E1)
// serialiser onto uart_tx. Optional even parity bit: define UART_TX_PARITY_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [UART_DATA_WL-1:0]       wr_data,
    input  logic                          clr_overflow,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          tx_done,
    output logic                          overflow,
    output logic                          uart_tx
);

    localparam int unsigned CPB       = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned STOP_CLKS = STOP_BITS * CPB;
    localparam int unsigned CNT_W     = $clog2(STOP_CLKS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
    localparam logic [CNT_W-1:0] STOP_PRE  = CNT_W'(STOP_CLKS - 2);

    tx_state_t               state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [2:0]              bit_idx_q;
    logic [UART_DATA_WL-1:0] shift_q;
    logic                    tx_q;
    logic                    done_q;
    logic                    overflow_q;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q;
`endif

    logic [UART_DATA_WL-1:0] fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;

    assign fifo_push = wr_en && !fifo_full;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (UART_DATA_WL),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign busy     = (state_q != IDLE);
    assign tx_done  = done_q;
    assign overflow = overflow_q;
    assign uart_tx  = tx_q;

    // Sticky overflow: a dropped push (full checked before any pop) beats a clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (wr_en && fifo_full) begin
            overflow_q <= 1'b1;
        end else if (clr_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    // Serialiser: uart_tx and tx_done are registered alongside the state so
    // the line changes exactly on state/bit boundaries.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    if (!fifo_empty) begin
                        shift_q  <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^fifo_dout;
`endif
                        tx_q     <= 1'b0;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            // Next bit is shift_q[1] before the shift lands.
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
`ifdef UART_TX_PARITY_EN
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`else
                    tx_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= IDLE;
`endif
                end
                STOP: begin
                    // Raised one cycle early so the pulse covers the final stop cycle.
                    if (cnt_q == STOP_PRE) begin
                        done_q <= 1'b1;
                    end
                    if (cnt_q == STOP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a cycle-level occupancy/timing model
// predicts status outputs, accepted bytes are queued, and a line decoder
// reassembles frames from uart_tx and checks them against the queue.
module tb_uart_tx_fifo;

    localparam int unsigned CLK_FREQ = 1000000;
    localparam int unsigned BAUD     = 100000;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned SB       = 1;
    localparam int unsigned C        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR      = 1;
`else
    localparam int unsigned PAR      = 0;
`endif
    localparam int unsigned FRAME    = (10 + SB - 1 + PAR) * C;
    localparam int unsigned LW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_overflow;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          busy;
    logic          tx_done;
    logic          overflow;
    logic          uart_tx;

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .FIFO_DEPTH (DEPTH),
        .STOP_BITS  (SB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .busy         (busy),
        .tx_done      (tx_done),
        .overflow     (overflow),
        .uart_tx      (uart_tx)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO occupancy plus "transmitter busy for one frame
    // after each pop"; pops happen only once the previous frame has ended.
    int unsigned m_cnt   = 0;
    int unsigned m_timer = 0;
    bit          m_ovf   = 1'b0;
    int unsigned cyc     = 0;
    bit          rst_seen = 1'b0;
    bit          m_pop;
    bit          m_acc;
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            m_cnt    = 0;
            m_timer  = 0;
            m_ovf    = 1'b0;
            exp_q.delete();
            start_q.delete();
            rst_seen = 1'b1;
        end else begin
            m_pop = (m_timer == 0) && (m_cnt > 0);
            m_acc = wr_en && (m_cnt < DEPTH);
            if (wr_en && !m_acc) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
            if (m_acc) exp_q.push_back(wr_data);
            m_cnt = m_cnt + (m_acc ? 1 : 0) - (m_pop ? 1 : 0);
            if (m_pop) begin
                m_timer = FRAME;
                start_q.push_back(cyc);
            end else if (m_timer > 0) begin
                m_timer--;
            end
        end
    end

    // Per-cycle status comparison against the model.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("level",    level,    m_cnt);
            check("empty",    empty,    (m_cnt == 0) ? 1 : 0);
            check("full",     full,     (m_cnt == DEPTH) ? 1 : 0);
            check("busy",     busy,     (m_timer > 0) ? 1 : 0);
            check("overflow", overflow, m_ovf);
            check("tx_done",  tx_done,  (m_timer == 1) ? 1 : 0);
            if (m_timer == 0) check("idle_line", uart_tx, 1);
        end
    end

    // Line monitor: decode frames by mid-bit sampling and pop the scoreboard.
    bit          mon_active = 1'b0;
    int unsigned mcnt       = 0;
    logic [7:0]  rx;
    logic [7:0]  exp_b;
    int unsigned exp_c;

    always @(negedge clk) begin
        if (rst_seen) begin
            mon_active = 1'b0;
            rst_seen   = 1'b0;
        end else if (cyc > 0) begin
            if (!mon_active) begin
                if (uart_tx === 1'b0) begin
                    mon_active = 1'b1;
                    mcnt       = 0;
                    if (start_q.size() == 0) begin
                        check("unexpected_start", 1, 0);
                    end else begin
                        exp_c = start_q.pop_front();
                        check("start_cycle", cyc, exp_c);
                    end
                end
            end
            if (mon_active) begin
                if ((mcnt % C) == (C / 2)) begin
                    if (mcnt / C == 0) begin
                        check("start_bit", uart_tx, 0);
                    end else if (mcnt / C <= 8) begin
                        rx[mcnt / C - 1] = uart_tx;
                    end else if (PAR == 1 && mcnt / C == 9) begin
                        check("parity_bit", uart_tx, ^rx);
                    end else begin
                        check("stop_bit", uart_tx, 1);
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", 1, 0);
                        end else begin
                            exp_b = exp_q.pop_front();
                            check("rx_byte", rx, exp_b);
                        end
                        mon_active = 1'b0;
                    end
                end
                mcnt++;
            end
        end
    end

    task automatic drive(input bit we, input logic [7:0] d, input bit clr);
        @(negedge clk);
        wr_en        = we;
        wr_data      = d;
        clr_overflow = clr;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int unsigned k = 0;
        while (!(m_cnt == 0 && m_timer == 0 && !mon_active) && k < 5000) begin
            drive(1'b0, 8'h00, 1'b0);
            k++;
        end
        check("drain_timeout", (k >= 5000) ? 1 : 0, 0);
        idle(3);
    endtask

    initial begin
        reset        = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Single byte.
        drive(1'b1, 8'hA5, 1'b0);
        drain();

        // Back-to-back pair.
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h0F, 1'b0);
        drain();

        // Overflow: sixth byte dropped, then clear.
        for (int unsigned i = 1; i <= 6; i++) drive(1'b1, 8'(i), 1'b0);
        drain();
        drive(1'b0, 8'h00, 1'b1);
        idle(2);

        // Reset during data bit 3 of 0xFF.
        drive(1'b1, 8'hFF, 1'b0);
        idle(45);
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        drain();

        // Parity-sensitive bytes.
        drive(1'b1, 8'h07, 1'b0);
        drain();
        drive(1'b1, 8'h03, 1'b0);
        drain();

        // Randomised traffic with occasional overflow clears.
        for (int unsigned i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(20, 150));
        end
        drain();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
